// File: rtl/axil_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// axil_if: AXI4-Lite bus bundle used by the configuration sequencer.
//   master modport : drives AW/W/AR channels and BREADY/RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY and the B/R channels
// Parameters: ADDR_W (address width), DATA_W (data width, 32 in practice).
// ---------------------------------------------------------------------------
interface axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// axil_cfg_sequencer: AXI4-Lite master that walks an external table of
// {offset, data, verify} entries, writing each one and optionally reading it
// back for comparison. Used to bring up a register bank after reset or on
// demand.
// Ports:
//   ACLK, ARESET       clock, synchronous active-high reset
//   start              1-cycle pulse, runs the table from entry 0 (ignored while busy)
//   busy               sequence in progress
//   done               1-cycle pulse when the sequence ends (success or error)
//   error              sticky failure flag, cleared by the next accepted start
//   err_code           01 bad BRESP/RRESP, 10 read-back mismatch, 11 timeout
//   err_idx            index of the failing entry
//   tbl_idx            entry index presented to the external table ROM
//   tbl_addr/data/verify  contents of entry tbl_idx (combinational lookup)
//   m_axi              AXI4-Lite master port
// ---------------------------------------------------------------------------
module axil_cfg_sequencer #(
    parameter int                N_ENTRIES = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 1023
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [7:0]        err_idx,
    output logic [7:0]        tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic              tbl_verify,
    axil_if.master            m_axi
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR, S_BRESP, S_RA, S_RD, S_NEXT, S_FIN
    } state_t;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  ERR_NONE  = 2'b00;
    localparam logic [1:0]  ERR_RESP  = 2'b01;
    localparam logic [1:0]  ERR_DATA  = 2'b10;
    localparam logic [1:0]  ERR_TMO   = 2'b11;
    localparam logic [7:0]  LAST_IDX  = 8'(N_ENTRIES - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

    state_t            state;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              verify_q;
    logic [31:0]       timer;
    logic              timer_hit;
    logic              wr_finish;
    logic              fail;
    logic [1:0]        fail_code;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = data_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    // The timer counts cycles spent in the current handshake state; it is
    // zeroed on every transition into WR/BRESP/RA/RD.
    assign timer_hit = (TIMEOUT != 0) && (timer == TMO_LAST);

    // A channel whose VALID has already dropped was accepted earlier, so the
    // write phase ends once each channel is either done or handshaking now.
    assign wr_finish = (!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        unique case (state)
            S_WR: begin
                if (!wr_finish && timer_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            S_BRESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end
                end else if (timer_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            S_RA: begin
                if (!m_axi.arready && timer_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            S_RD: begin
                if (m_axi.rvalid) begin
                    if (m_axi.rresp != RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end else if (m_axi.rdata != data_q) begin
                        fail      = 1'b1;
                        fail_code = ERR_DATA;
                    end
                end else if (timer_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; later assignments in the block override earlier
    // defaults (done, timer) for the same edge.
    always_ff @(posedge ACLK) begin
        // NOTE: reset is synchronous because the slave shares ARESET and must
        // see the master's VALIDs drop on the same edge it resets itself.
        if (ARESET) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            err_idx   <= '0;
            tbl_idx   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            verify_q  <= 1'b0;
            timer     <= '0;
        end else begin
            done  <= 1'b0;
            timer <= timer + 32'd1;
            if (fail) begin
                // On timeout the slave is assumed hung: VALIDs drop without
                // waiting for a handshake.
                error     <= 1'b1;
                err_code  <= fail_code;
                err_idx   <= tbl_idx;
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                state     <= S_FIN;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            tbl_idx  <= '0;
                            busy     <= 1'b1;
                            error    <= 1'b0;
                            err_code <= ERR_NONE;
                            err_idx  <= '0;
                            state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        addr_q    <= tbl_addr + BASE_ADDR;
                        data_q    <= tbl_data;
                        verify_q  <= tbl_verify;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        timer     <= '0;
                        state     <= S_WR;
                    end
                    S_WR: begin
                        if (m_axi.awready) awvalid_q <= 1'b0;
                        if (m_axi.wready)  wvalid_q  <= 1'b0;
                        if (wr_finish) begin
                            bready_q <= 1'b1;
                            timer    <= '0;
                            state    <= S_BRESP;
                        end
                    end
                    S_BRESP: begin
                        if (m_axi.bvalid) begin
                            bready_q <= 1'b0;
                            if (verify_q) begin
                                arvalid_q <= 1'b1;
                                timer     <= '0;
                                state     <= S_RA;
                            end else begin
                                state <= S_NEXT;
                            end
                        end
                    end
                    S_RA: begin
                        if (m_axi.arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            timer     <= '0;
                            state     <= S_RD;
                        end
                    end
                    S_RD: begin
                        if (m_axi.rvalid) begin
                            rready_q <= 1'b0;
                            state    <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (tbl_idx == LAST_IDX) begin
                            state <= S_FIN;
                        end else begin
                            tbl_idx <= tbl_idx + 8'd1;
                            state   <= S_FETCH;
                        end
                    end
                    S_FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axil_cfg_sequencer: directed bench for axil_cfg_sequencer with a small
// AXI4-Lite slave model (configurable ready skew, BRESP error injection,
// RDATA corruption, hung AR channel) and a 4-entry table ROM.
// ---------------------------------------------------------------------------
module tb_axil_cfg_sequencer;
    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        tb_ACLK = 1'b0;
    logic        ARESET;
    logic        start;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [7:0]  err_idx, tbl_idx;
    logic [31:0] tbl_addr, tbl_data;
    logic        tbl_verify;

    always #5 tb_ACLK = ~tb_ACLK;

    axil_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_cfg_sequencer #(
        .N_ENTRIES(N), .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .TIMEOUT(15)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .start(start),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_idx(err_idx), .tbl_idx(tbl_idx),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_verify(tbl_verify),
        .m_axi(bus)
    );

    // ---------------- table ROM ----------------
    logic [31:0] tbl_off [N] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] tbl_dat [N] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    logic        tbl_ver [N] = '{1'b1, 1'b1, 1'b1, 1'b1};

    assign tbl_addr   = (tbl_idx < 8'(N)) ? tbl_off[tbl_idx[1:0]] : 32'h0;
    assign tbl_data   = (tbl_idx < 8'(N)) ? tbl_dat[tbl_idx[1:0]] : 32'h0;
    assign tbl_verify = (tbl_idx < 8'(N)) ? tbl_ver[tbl_idx[1:0]] : 1'b0;

    // ---------------- slave model ----------------
    int          skew_mode   = 0;   // alternate AW-first / W-first by 3 cycles
    int          bresp_err_w = -1;  // write number answered with SLVERR
    int          corrupt_r   = -1;  // read number returned as 0xabcd0000
    bit          ar_hang     = 1'b0;
    logic [31:0] mem [16];
    logic [31:0] aw_log [16];
    int          aw_n, w_n, b_n, ar_n, r_n;
    int          aw_wait, w_wait, aw_lat, w_lat;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, w_data_q;
    logic        aw_hs, w_hs, wa, ww;

    always_comb begin
        aw_lat = 0;
        w_lat  = 0;
        if (skew_mode != 0) begin
            aw_lat = (b_n % 2 == 0) ? 0 : 3;
            w_lat  = (b_n % 2 == 0) ? 3 : 0;
        end
    end

    assign bus.awready = bus.awvalid && !aw_got && (aw_wait >= aw_lat);
    assign bus.wready  = bus.wvalid && !w_got && (w_wait >= w_lat);
    assign bus.arready = bus.arvalid && !ar_hang && !bus.rvalid;
    assign bus.rresp   = 2'b00;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign wa    = aw_got || aw_hs;
    assign ww    = w_got || w_hs;

    always @(posedge tb_ACLK) begin
        if (ARESET) begin
            aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0; r_n <= 0;
            aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rdata <= '0;
            for (int i = 0; i < 16; i++) begin
                mem[i]    <= '0;
                aw_log[i] <= '0;
            end
        end else begin
            if (bus.awvalid && !bus.awready) aw_wait <= aw_wait + 1;
            if (bus.wvalid && !bus.wready)   w_wait  <= w_wait + 1;
            if (aw_hs) begin
                aw_wait   <= 0;
                aw_got    <= 1'b1;
                aw_addr_q <= bus.awaddr;
                if (aw_n < 16) aw_log[aw_n] <= bus.awaddr;
                aw_n <= aw_n + 1;
            end
            if (w_hs) begin
                w_wait   <= 0;
                w_got    <= 1'b1;
                w_data_q <= bus.wdata;
                w_n      <= w_n + 1;
            end
            if (wa && ww && !bus.bvalid) begin
                mem[aw_hs ? bus.awaddr[5:2] : aw_addr_q[5:2]] <= w_hs ? bus.wdata : w_data_q;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                bus.bvalid <= 1'b1;
                bus.bresp  <= (b_n == bresp_err_w) ? 2'b10 : 2'b00;
            end
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                b_n        <= b_n + 1;
            end
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= (ar_n == corrupt_r) ? 32'habcd0000 : mem[bus.araddr[5:2]];
                ar_n       <= ar_n + 1;
            end
            if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
                r_n        <= r_n + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge tb_ACLK);
        ARESET = 1'b1;
        start  = 1'b0;
        repeat (2) @(negedge tb_ACLK);
        ARESET = 1'b0;
    endtask

    // Pulses start, then counts posedges (start edge included) until done is seen.
    task automatic run_seq(output int n_edges, output logic busy_1, output logic err_1,
                           output logic got_done);
        @(negedge tb_ACLK);
        start = 1'b1;
        @(negedge tb_ACLK);
        start   = 1'b0;
        busy_1  = busy;
        err_1   = error;
        n_edges = 1;
        while (!done && n_edges < 400) begin
            @(negedge tb_ACLK);
            n_edges++;
        end
        got_done = done;
    endtask

    int   cyc, k;
    logic b1, e1, gd;

    initial begin
        ARESET = 1'b1;
        start  = 1'b0;

        // ---- reset state ----
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_err_idx", err_idx, 0);
        check("rst_tbl_idx", tbl_idx, 0);
        check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        check("rst_readys", {bus.bready, bus.rready}, 0);

        // ---- 1: zero-wait slave, all entries verified ----
        run_seq(cyc, b1, e1, gd);
        check("t1_busy_after_1", b1, 1);
        check("t1_done_seen", gd, 1);
        check("t1_done_cycles", cyc, 1 + 4 * 6 + 1);
        check("t1_error", error, 0);
        check("t1_busy_at_done", busy, 0);
        check("t1_writes", aw_n, 4);
        check("t1_reads", ar_n, 4);
        check("t1_addr0", aw_log[0], 32'h4000_0000);
        check("t1_addr3", aw_log[3], 32'h4000_000C);
        check("t1_mem0", mem[0], 32'h0101FFFF);
        check("t1_mem3", mem[3], 32'hbeef0011);
        @(negedge tb_ACLK);
        check("t1_done_pulse", done, 0);

        // ---- 2: skewed AW/W acceptance, entries 1 and 3 not verified ----
        do_reset();
        skew_mode  = 1;
        tbl_ver[1] = 1'b0;
        tbl_ver[3] = 1'b0;
        run_seq(cyc, b1, e1, gd);
        check("t2_done_seen", gd, 1);
        check("t2_error", error, 0);
        check("t2_aw_count", aw_n, 4);
        check("t2_w_count", w_n, 4);
        check("t2_b_count", b_n, 4);
        check("t2_reads", ar_n, 2);
        check("t2_mem1", mem[1], 32'habcd0001);
        check("t2_mem2", mem[2], 32'hdead0011);
        skew_mode  = 0;
        tbl_ver[1] = 1'b1;
        tbl_ver[3] = 1'b1;

        // ---- 3: SLVERR on write of entry 2 ----
        do_reset();
        bresp_err_w = 2;
        run_seq(cyc, b1, e1, gd);
        check("t3_done_seen", gd, 1);
        check("t3_error", error, 1);
        check("t3_err_code", err_code, 2'b01);
        check("t3_err_idx", err_idx, 2);
        check("t3_writes", aw_n, 3);
        check("t3_reads", ar_n, 2);
        bresp_err_w = -1;

        // ---- 4: corrupted read-back of entry 1 ----
        do_reset();
        corrupt_r = 1;
        run_seq(cyc, b1, e1, gd);
        check("t4_done_seen", gd, 1);
        check("t4_error", error, 1);
        check("t4_err_code", err_code, 2'b10);
        check("t4_err_idx", err_idx, 1);
        check("t4_writes", aw_n, 2);
        corrupt_r = -1;

        // ---- 5: AR channel hung, timeout 15 cycles after ARVALID rises ----
        do_reset();
        ar_hang = 1'b1;
        @(negedge tb_ACLK);
        start = 1'b1;
        @(negedge tb_ACLK);
        start = 1'b0;
        k = 0;
        while (!bus.arvalid && k < 100) begin
            @(negedge tb_ACLK);
            k++;
        end
        check("t5_arvalid_rose", bus.arvalid, 1);
        cyc = 0;
        while (!error && cyc < 100) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        check("t5_timeout_latency", cyc, 15);
        check("t5_err_code", err_code, 2'b11);
        check("t5_err_idx", err_idx, 0);
        check("t5_arvalid_dropped", bus.arvalid, 0);
        k = 0;
        while (!done && k < 20) begin
            @(negedge tb_ACLK);
            k++;
        end
        check("t5_done_seen", done, 1);
        ar_hang = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        check("t5_error_sticky", error, 1);

        // ---- 6: reset during WR of entry 1, then a clean replay ----
        @(negedge tb_ACLK);
        start = 1'b1;
        @(negedge tb_ACLK);
        start = 1'b0;
        check("t6_error_cleared_by_start", error, 0);
        k = 0;
        while (!(bus.awvalid && tbl_idx == 8'd1) && k < 100) begin
            @(negedge tb_ACLK);
            k++;
        end
        check("t6_in_wr_entry1", {bus.awvalid, tbl_idx}, {1'b1, 8'd1});
        ARESET = 1'b1;
        @(negedge tb_ACLK);
        ARESET = 1'b0;
        check("t6_valids_dropped", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        check("t6_busy_dropped", busy, 0);
        run_seq(cyc, b1, e1, gd);
        check("t6_replay_done", gd, 1);
        check("t6_replay_cycles", cyc, 26);
        check("t6_replay_error", error, 0);
        check("t6_replay_addr0", aw_log[0], 32'h4000_0000);
        check("t6_replay_writes", aw_n, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
